// File: rtl/int_ctrl_prio_pkg.sv
// rtl/int_ctrl_prio_pkg.sv - shared FSM states and config address map for the vectored interrupt controller
package int_ctrl_prio_pkg;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_REQ  = 1'b1
    } state_t;

    // Config map: vectors occupy 0..nch-1, control registers follow
    function automatic int a_mask(input int nch);
        return nch;
    endfunction

    function automatic int a_mode(input int nch);
        return nch + 1;
    endfunction

    function automatic int a_trig(input int nch);
        return nch + 2;
    endfunction

endpackage

// File: rtl/int_ctrl_prio_if.sv
// rtl/int_ctrl_prio_if.sv - core handshake and config bus between CPU core and interrupt controller
interface int_ctrl_prio_if #(
    parameter int NCH  = 4,
    parameter int PC_W = 10
);
    localparam int AW  = $clog2(NCH + 3);
    localparam int AWC = $clog2(NCH);

    logic            gie;
    logic            irq_ack;
    logic            reti;
    logic            irq_req;
    logic [AWC-1:0]  irq_id;
    logic [PC_W-1:0] irq_vec;
    logic            cfg_we;
    logic [AW-1:0]   cfg_addr;
    logic [PC_W-1:0] cfg_wdata;
    logic [PC_W-1:0] cfg_rdata;

    // Core side
    modport master (
        output gie, irq_ack, reti, cfg_we, cfg_addr, cfg_wdata,
        input  irq_req, irq_id, irq_vec, cfg_rdata
    );

    // Controller side
    modport slave (
        input  gie, irq_ack, reti, cfg_we, cfg_addr, cfg_wdata,
        output irq_req, irq_id, irq_vec, cfg_rdata
    );
endinterface

// File: rtl/int_ctrl_prio_prio_enc.sv
// rtl/int_ctrl_prio_prio_enc.sv - lowest-index-first priority encoder
module prio_enc #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    output logic          valid,
    output logic [IW-1:0] idx
);

    // Scan from the top down so the lowest set bit is the last to win
    always_comb begin
        valid = |req;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = IW'(i);
            end
        end
    end

endmodule

// File: rtl/int_ctrl_prio.sv
// rtl/int_ctrl_prio.sv - parametrised priority-nested vectored interrupt controller
module int_ctrl_prio
    import int_ctrl_prio_pkg::*;
#(
    parameter int              NCH        = 4,
    parameter int              PC_W       = 10,
    parameter logic [PC_W-1:0] VEC_BASE   = 'h3F0,
    parameter int              VEC_STRIDE = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NCH-1:0]  irq_in,
    int_ctrl_prio_if.slave  bus,
    output logic [NCH-1:0]  pending_o,
    output logic [NCH-1:0]  isr_o
);

    localparam int AW     = $clog2(NCH + 3);
    localparam int AWC    = $clog2(NCH);
    localparam int A_MASK = a_mask(NCH);
    localparam int A_MODE = a_mode(NCH);
    localparam int A_TRIG = a_trig(NCH);

    function automatic logic [PC_W-1:0] vec_reset(input int i);
        return PC_W'(int'(VEC_BASE) + i * VEC_STRIDE);
    endfunction

    state_t          state_q, state_d;
    logic [NCH-1:0]  irq_in_q;
    logic [NCH-1:0]  pending_q, isr_q, mask_q, mode_q;
    logic [PC_W-1:0] vectors_q [NCH];
    logic [AWC-1:0]  irq_id_q;
    logic [PC_W-1:0] irq_vec_q;
    logic [PC_W-1:0] rdata;

    logic            load_req, ack_fire;
    logic            wr_mask, wr_mode, wr_trig;
    logic [NCH-1:0]  set_vec, ack_vec, reti_vec;
    logic [NCH-1:0]  isr_lowest, prio_above, eligible;
    logic            elig_valid, isr_valid;
    logic [AWC-1:0]  elig_idx, isr_idx;

    assign wr_mask = bus.cfg_we && (bus.cfg_addr == AW'(A_MASK));
    assign wr_mode = bus.cfg_we && (bus.cfg_addr == AW'(A_MODE));
    assign wr_trig = bus.cfg_we && (bus.cfg_addr == AW'(A_TRIG));

    // Edge channels fire on a rising input, level channels whenever high
    assign set_vec = (~mode_q & irq_in & ~irq_in_q) | (mode_q & irq_in)
                   | (wr_trig ? bus.cfg_wdata[NCH-1:0] : '0);

    // Isolating the lowest isr bit and subtracting one yields all channels
    // of strictly higher priority; with isr empty it wraps to all ones.
    assign isr_lowest = isr_q & (~isr_q + NCH'(1));
    assign prio_above = isr_lowest - NCH'(1);
    assign eligible   = pending_q & mask_q & prio_above;

    prio_enc #(.N(NCH), .IW(AWC)) u_elig_enc (
        .req   (eligible),
        .valid (elig_valid),
        .idx   (elig_idx)
    );

    prio_enc #(.N(NCH), .IW(AWC)) u_isr_enc (
        .req   (isr_q),
        .valid (isr_valid),
        .idx   (isr_idx)
    );

    assign ack_vec  = ack_fire ? (NCH'(1) << irq_id_q) : '0;
    assign reti_vec = (bus.reti && isr_valid) ? (NCH'(1) << isr_idx) : '0;

    // Input history, pending latch (set beats clear) and nesting register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_in_q  <= '0;
            pending_q <= '0;
            isr_q     <= '0;
        end else begin
            irq_in_q  <= irq_in;
            pending_q <= (pending_q & ~ack_vec) | set_vec;
            isr_q     <= (isr_q & ~reti_vec) | ack_vec;
        end
    end

    // Configuration registers and vector table
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mask_q <= '1;
            mode_q <= '0;
            for (int i = 0; i < NCH; i++) begin
                vectors_q[i] <= vec_reset(i);
            end
        end else begin
            if (wr_mask) mask_q <= bus.cfg_wdata[NCH-1:0];
            if (wr_mode) mode_q <= bus.cfg_wdata[NCH-1:0];
            for (int i = 0; i < NCH; i++) begin
                if (bus.cfg_we && (bus.cfg_addr == AW'(i))) begin
                    vectors_q[i] <= bus.cfg_wdata;
                end
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: hold one request until the core acknowledges it
    always_comb begin
        state_d  = state_q;
        load_req = 1'b0;
        ack_fire = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.gie && elig_valid) begin
                    state_d  = S_REQ;
                    load_req = 1'b1;
                end
            end
            S_REQ: begin
                if (bus.irq_ack) begin
                    state_d  = S_IDLE;
                    ack_fire = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Capture id and vector once so later config writes cannot disturb them
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_id_q  <= '0;
            irq_vec_q <= '0;
        end else if (load_req) begin
            irq_id_q  <= elig_idx;
            irq_vec_q <= vectors_q[elig_idx];
        end
    end

    // Combinational config read; the trigger address exposes pending
    always_comb begin
        rdata = '0;
        for (int i = 0; i < NCH; i++) begin
            if (bus.cfg_addr == AW'(i)) rdata = vectors_q[i];
        end
        if (bus.cfg_addr == AW'(A_MASK)) rdata = PC_W'(mask_q);
        if (bus.cfg_addr == AW'(A_MODE)) rdata = PC_W'(mode_q);
        if (bus.cfg_addr == AW'(A_TRIG)) rdata = PC_W'(pending_q);
    end

    assign bus.irq_req   = (state_q == S_REQ);
    assign bus.irq_id    = irq_id_q;
    assign bus.irq_vec   = irq_vec_q;
    assign bus.cfg_rdata = rdata;
    assign pending_o     = pending_q;
    assign isr_o         = isr_q;

endmodule
